// File: rtl/fixed_cast_rr_scheduler_if.sv
// Stream bundle for fixed_cast_rr_scheduler: NUM_REQ packed input words with
// per-requester valid/ready, and one cast-result stream tagged with requester id.
interface fixed_cast_rr_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ*IN_WIDTH-1:0] data_in_0;
    logic [NUM_REQ-1:0]          data_in_0_valid;
    logic [NUM_REQ-1:0]          data_in_0_ready;
    logic [OUT_WIDTH-1:0]        data_out_0;
    logic [ID_W-1:0]             data_out_0_id;
    logic                        data_out_0_valid;
    logic                        data_out_0_ready;

    // Scheduler side: consumes the requester streams, produces the result stream.
    modport slave (
        input  data_in_0,
        input  data_in_0_valid,
        output data_in_0_ready,
        output data_out_0,
        output data_out_0_id,
        output data_out_0_valid,
        input  data_out_0_ready
    );

    // Environment side: drives requesters and sinks results.
    modport master (
        output data_in_0,
        output data_in_0_valid,
        input  data_in_0_ready,
        input  data_out_0,
        input  data_out_0_id,
        input  data_out_0_valid,
        output data_out_0_ready
    );
endinterface

// File: rtl/fixed_cast_rr_scheduler.sv
// Round-robin arbiter feeding a 2-stage floor-round/clamp fixed-point cast lane.
// Define FIXED_CAST_SAT_COUNT_EN to build the saturated-result counter (else sat_count is 0).
module fixed_cast_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int IN_WIDTH       = 16,
    parameter int IN_FRAC_WIDTH  = 8,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_FRAC_WIDTH = 4,
    parameter int SYMMETRIC      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    fixed_cast_rr_scheduler_if.slave bus,
    output logic [31:0]              sat_count
);
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SHIFT_L = (OUT_FRAC_WIDTH >= IN_FRAC_WIDTH) ? (OUT_FRAC_WIDTH - IN_FRAC_WIDTH) : 0;
    localparam int SHIFT_R = (IN_FRAC_WIDTH > OUT_FRAC_WIDTH) ? (IN_FRAC_WIDTH - OUT_FRAC_WIDTH) : 0;
    localparam int RND_W   = IN_WIDTH + SHIFT_L;
    // One guard bit above the wider of rounded value and output keeps the clamp compare exact.
    localparam int EXT_W   = ((RND_W > OUT_WIDTH) ? RND_W : OUT_WIDTH) + 1;

    localparam int MAX_I = (1 << (OUT_WIDTH - 1)) - 1;
    localparam int MIN_I = (SYMMETRIC != 0) ? -MAX_I : -MAX_I - 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(MAX_I);
    localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(MIN_I);
    localparam logic [OUT_WIDTH-1:0]    MAX_O = OUT_WIDTH'(MAX_I);
    localparam logic [OUT_WIDTH-1:0]    MIN_O = OUT_WIDTH'(MIN_I);

    logic [IN_WIDTH-1:0] word_in [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign word_in[gi] = bus.data_in_0[gi*IN_WIDTH +: IN_WIDTH];
    end

    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic            s1_valid_q, s1_valid_d;
    logic [EXT_W-1:0] s1_value_q, s1_value_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    int              cand_i;

    // Rotating priority: the search begins one past the last accepted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_i      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_i = int'(last_grant_q) + k;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end
            if (!grant_found && bus.data_in_0_valid[ID_W'(cand_i)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand_i);
            end
        end
    end

    logic [IN_WIDTH-1:0]     sel_word;
    logic signed [EXT_W-1:0] ext_word;
    logic signed [EXT_W-1:0] rnd_value;

    assign sel_word  = word_in[grant_idx];
    assign ext_word  = signed'({{(EXT_W - IN_WIDTH){sel_word[IN_WIDTH-1]}}, sel_word});
    // Arithmetic right shift is floor rounding; exactly one of the two shifts is non-zero.
    assign rnd_value = (ext_word <<< SHIFT_L) >>> SHIFT_R;

    logic signed [EXT_W-1:0] s1_value_s;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_WIDTH-1:0]    clamp_value;

    assign s1_value_s  = signed'(s1_value_q);
    assign sat_hi      = s1_value_s > MAX_V;
    assign sat_lo      = s1_value_s < MIN_V;
    assign clamp_value = sat_hi ? MAX_O : (sat_lo ? MIN_O : s1_value_q[OUT_WIDTH-1:0]);

    logic s2_ready;
    logic s1_ready;
    logic accept;
    logic advance;
    logic out_fire;

    assign s2_ready = !s2_valid_q || bus.data_out_0_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign accept   = grant_found && s1_ready && rst;
    assign advance  = s1_valid_q && s2_ready;
    assign out_fire = s2_valid_q && bus.data_out_0_ready;

    always_comb begin
        bus.data_in_0_ready = '0;
        if (accept) begin
            bus.data_in_0_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        s1_valid_d   = s1_valid_q;
        s1_value_d   = s1_value_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_id_d      = s2_id_q;

        if (accept) begin
            last_grant_d = grant_idx;
            s1_valid_d   = 1'b1;
            s1_value_d   = rnd_value;
            s1_id_d      = grant_idx;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        if (advance) begin
            s2_valid_d = 1'b1;
            s2_data_d  = clamp_value;
            s2_id_d    = s1_id_q;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            s1_valid_q   <= 1'b0;
            s1_value_q   <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_id_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_value_q   <= s1_value_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_id_q      <= s2_id_d;
        end
    end

    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    assign bus.data_out_0_valid = s2_valid_q && rst;
    assign bus.data_out_0       = rst ? s2_data_q : '0;
    assign bus.data_out_0_id    = rst ? s2_id_q : '0;

`ifdef FIXED_CAST_SAT_COUNT_EN
    logic        s2_sat_q, s2_sat_d;
    logic [31:0] sat_count_q, sat_count_d;

    always_comb begin
        s2_sat_d    = s2_sat_q;
        sat_count_d = sat_count_q;
        if (advance) begin
            s2_sat_d = sat_hi || sat_lo;
        end
        if (out_fire && s2_sat_q && (sat_count_q != 32'hFFFF_FFFF)) begin
            sat_count_d = sat_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s2_sat_q    <= s2_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = rst ? sat_count_q : '0;
`else
    assign sat_count = '0;
`endif

endmodule

// File: doc/fixed_cast_rr_scheduler.md
FIXED_CAST_RR_SCHEDULER -- requirements
Module: fixed_cast_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requester streams sharing one cast lane (2..16).
REQ-002 SHALL have parameter IN_WIDTH, default 16: input word width, signed.
REQ-003 SHALL have parameter IN_FRAC_WIDTH, default 8: input fractional bits.
REQ-004 SHALL have parameter OUT_WIDTH, default 8: output word width, signed.
REQ-005 SHALL have parameter OUT_FRAC_WIDTH, default 4: output fractional bits.
REQ-006 SHALL have parameter SYMMETRIC, default 0: 1 gives output range +/-(2^(OUT_WIDTH-1)-1); 0 gives -2^(OUT_WIDTH-1)..2^(OUT_WIDTH-1)-1.
REQ-007 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-low reset (asserted when 0).
REQ-009 SHALL have port data_in_0, input, NUM_REQ x IN_WIDTH packed: one signed word per requester.
REQ-010 SHALL have port data_in_0_valid, input, NUM_REQ: per-requester valid.
REQ-011 SHALL have port data_in_0_ready, output, NUM_REQ: per-requester ready.
REQ-012 SHALL have port data_out_0, output, OUT_WIDTH: cast result.
REQ-013 SHALL have port data_out_0_id, output, $clog2(NUM_REQ): index of the requester that produced data_out_0.
REQ-014 SHALL have port data_out_0_valid, output, 1; and data_out_0_ready, input, 1: output handshake.
REQ-015 SHALL have port sat_count, output, 32: number of results that were clamped.

Function
REQ-016 SHALL transfer on any interface exactly when valid and ready are both 1 on a rising edge.
REQ-017 SHALL assert at most one bit of data_in_0_ready per cycle, only for the granted requester, and only when stage 1 can accept (empty, or advancing this cycle).
REQ-018 SHALL grant round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on an accepted transfer; a requester with valid=0 is skipped with no idle cycle.
REQ-019 SHALL implement a 2-stage pipeline: S1 registers the floor-rounded value and id; S2 registers the clamped value, id and saturation flag; data_out_0 comes from S2.
REQ-020 SHALL have latency 2 cycles from acceptance to data_out_0_valid and throughput 1 word/cycle with data_out_0_ready held high.
REQ-021 SHALL advance each stage when the downstream stage is empty or is being consumed in the same cycle; a stalled stage holds its data and valid unchanged (no drop, no duplication).
REQ-022 SHALL round by floor: if OUT_FRAC_WIDTH<IN_FRAC_WIDTH, arithmetic right shift by the difference; otherwise sign-extend and left shift with zero fill; intermediate width sufficient that no bit is lost before clamping.
REQ-023 SHALL clamp the rounded value to the range from REQ-006 and flag saturation when the value lay outside that range.
REQ-024 SHALL increment sat_count by 1 when a saturated result completes an output handshake; it saturates at 0xFFFFFFFF and never wraps.
REQ-025 SHALL NOT let data_out_0_valid depend combinationally on data_out_0_ready; data_in_0_ready may depend combinationally on data_in_0_valid and data_out_0_ready.

Reset
REQ-026 SHALL, with rst=0 at a rising edge: clear S1/S2 valid, set last_grant to NUM_REQ-1 (so requester 0 has first priority), and clear sat_count.
REQ-027 SHALL drive data_in_0_ready=0, data_out_0_valid=0, data_out_0=0, data_out_0_id=0 and sat_count=0 while rst=0.
REQ-028 SHALL discard in-flight words on reset asserted mid-operation; the first post-reset grant goes to the lowest-index valid requester.

Configuration
REQ-029 SHALL compile the saturation counter only when macro FIXED_CAST_SAT_COUNT_EN is defined; when undefined, sat_count is tied to 0, no counter logic is built, and all other behaviour is identical.

Verification
REQ-030 SHALL cover: defaults, requester 0 sends 0x0180 (1.5), out_ready=1 -> data_out_0=0x18, id=0, valid exactly 2 cycles after acceptance.
REQ-031 SHALL cover: inputs 0x7FFF -> 0x7F; 0x8000 -> 0x80 with SYMMETRIC=0 and 0x81 with SYMMETRIC=1; 0xFFF8 -> 0xFF (floor); with macro defined, sat_count=3 after these four completions.
REQ-032 SHALL cover: all 4 requesters valid continuously, out_ready=1 -> ids 0,1,2,3,0,1 on consecutive cycles; with only 1 and 3 valid -> ids alternate 1,3,1,3 with no bubbles.
REQ-033 SHALL cover: out_ready=0 for 6 cycles under full load -> exactly 2 words accepted, then all data_in_0_ready=0, data_out_0 stable; on release words emerge in acceptance order, none lost.
REQ-034 SHALL cover: rst=0 for one cycle with both stages full -> next cycle data_out_0_valid=0, sat_count=0; first post-reset result has id of lowest-index valid requester.
REQ-035 SHALL cover: macro undefined, repeated 0x7FFF inputs -> data_out_0=0x7F each time, sat_count remains 0.
